// File: rtl/dbns_pkg.sv
// Shared DBNS types and constants used by the converter, the multiplier and the scheduler.
package dbns_pkg;

  localparam int DBNS_IN_W     = 16;
  localparam int DBNS_OUT_W    = 32;
  localparam int DBNS_CONV_LAT = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CRST = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } sched_state_t;

  // Counter width that can hold the longer of the two phase lengths without wrapping.
  function automatic int dbns_cnt_w(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/dbns_rr_arb2.sv
// Two-input round-robin arbiter: a lone request wins, a tie goes to the port that was not granted last.
module dbns_rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  input  logic       enable,
  output logic [1:0] grant
);

  // One-hot grant, zero when disabled or nothing is requesting.
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (valid == 2'b11) grant = last ? 2'b01 : 2'b10;
      else                grant = valid;
    end
  end

endmodule

// File: rtl/dbns_conv_sched.sv
// Shares one fixed-latency DBNS converter between the operand-A and operand-B requesters.
// Each conversion runs reset -> run -> respond; the converter output is captured only on the
// final run cycle and held until the consumer takes it.
module dbns_conv_sched
  import dbns_pkg::*;
#(
  parameter int IN_W     = DBNS_IN_W,
  parameter int OUT_W    = DBNS_OUT_W,
  parameter int RST_CYC  = 2,
  parameter int CONV_LAT = DBNS_CONV_LAT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  input  logic [IN_W-1:0]  req_data0,
  input  logic [IN_W-1:0]  req_data1,
  output logic [1:0]       req_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [OUT_W-1:0] rsp_data,
  input  logic             rsp_ready,
  output logic             conv_rst,
  output logic [IN_W-1:0]  conv_in,
  input  logic [OUT_W-1:0] conv_out,
  output logic             busy
);

  localparam int              CNT_W    = dbns_cnt_w(RST_CYC, CONV_LAT);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(CONV_LAT - 1);

  sched_state_t     state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             last_grant;
  logic [1:0]       grant;
  logic             accept;
  logic             acc_id;
  logic             rst_done;
  logic             run_done;

  dbns_rr_arb2 u_arb (
    .valid  (req_valid),
    .last   (last_grant),
    .enable (state == IDLE),
    .grant  (grant)
  );

  assign req_ready = grant;
  assign accept    = |(req_valid & grant);
  assign acc_id    = grant[1];
  assign rst_done  = (cnt == RST_LAST);
  assign run_done  = (cnt == RUN_LAST);

  // Outputs decoded from state so an asynchronous reset takes effect on them at once.
  assign conv_rst  = (state != RUN);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  // Next-state sequencing of one conversion.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = CRST;
      CRST:    if (rst_done)  state_nxt = RUN;
      RUN:     if (run_done)  state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // State, phase counter, accepted operand/owner and the captured converter result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      conv_in    <= '0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt        <= '0;
            conv_in    <= acc_id ? req_data1 : req_data0;
            rsp_id     <= acc_id;
            last_grant <= acc_id;
          end
        end
        CRST: cnt <= rst_done ? '0 : cnt + CNT_W'(1);
        RUN: begin
          if (run_done) begin
            cnt      <= '0;
            rsp_data <= conv_out;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dbns_conv_sched.sv
// Directed bench for dbns_conv_sched with a behavioural fixed-latency converter model.
module tb_dbns_conv_sched;

  localparam int IN_W     = 16;
  localparam int OUT_W    = 32;
  localparam int RST_CYC  = 2;
  localparam int CONV_LAT = 20;
  // Edges from accept to the first sample showing rsp_valid (rsp_valid's cycle is t+23).
  localparam int RSP_EDGES = RST_CYC + CONV_LAT;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [IN_W-1:0]  req_data0, req_data1;
  logic [1:0]       req_ready;
  logic             rsp_valid, rsp_id;
  logic [OUT_W-1:0] rsp_data;
  logic             rsp_ready;
  logic             conv_rst;
  logic [IN_W-1:0]  conv_in;
  logic [OUT_W-1:0] conv_out;
  logic             busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int mcnt     = 0;

  dbns_conv_sched #(
    .IN_W(IN_W), .OUT_W(OUT_W), .RST_CYC(RST_CYC), .CONV_LAT(CONV_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data0(req_data0),
    .req_data1(req_data1), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .conv_rst(conv_rst), .conv_in(conv_in), .conv_out(conv_out), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Converter model: counts cycles spent out of reset, output meaningful only after CONV_LAT.
  always @(negedge clk) mcnt <= conv_rst ? 0 : mcnt + 1;
  assign conv_out = (mcnt >= CONV_LAT) ? {16'hA5A5, conv_in} : 'x;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after an accept until rsp_valid is seen, and cycles with conv_rst low.
  task automatic wait_rsp(output int edges, output int low);
    edges = 0;
    low   = 0;
    while (1) begin
      tick();
      edges++;
      if (!conv_rst) low++;
      if (rsp_valid || edges > 100) break;
    end
  endtask

  initial begin
    int lat, low, ok, t_prev, t_now;
    logic [15:0] vals [3];
    vals[0] = 16'h1111; vals[1] = 16'hCAFE; vals[2] = 16'h0007;

    rst_n = 1'b0; req_valid = 2'b00; req_data0 = '0; req_data1 = '0; rsp_ready = 1'b0;
    tick(); tick();
    chk("rst_conv_rst", conv_rst, 1);
    chk("rst_conv_in", conv_in, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    rst_n = 1'b1;
    tick();

    // Single request from port 0.
    req_valid = 2'b01; req_data0 = 16'd3888;
    #1 chk("single_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    chk("single_busy", busy, 1);
    chk("single_conv_in", conv_in, 16'd3888);
    wait_rsp(lat, low);
    chk("single_lat", lat, RSP_EDGES);
    chk("single_low", low, CONV_LAT);
    chk("single_id", rsp_id, 0);
    chk("single_data", rsp_data, 32'hA5A5_0F30);
    chk("single_resp_conv_rst", conv_rst, 1);
    rsp_ready = 1'b1;
    tick();
    chk("single_idle", busy, 0);
    chk("single_rsp_drop", rsp_valid, 0);

    // Simultaneous requests straight out of reset.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req_valid = 2'b11; req_data0 = 16'd1; req_data1 = 16'd2;
    #1 chk("tie_first_grant", req_ready, 2'b01);
    tick();
    wait_rsp(lat, low);
    chk("tie_a_lat", lat, RSP_EDGES);
    chk("tie_a_id", rsp_id, 0);
    chk("tie_a_data", rsp_data, 32'hA5A5_0001);
    tick();
    chk("tie_second_grant", req_ready, 2'b10);
    tick();
    wait_rsp(lat, low);
    chk("tie_b_id", rsp_id, 1);
    chk("tie_b_data", rsp_data, 32'hA5A5_0002);
    tick();
    chk("tie_third_grant", req_ready, 2'b01);
    req_valid = 2'b00;
    tick();

    // Backpressure in RESP.
    rsp_ready = 1'b0;
    req_valid = 2'b01; req_data0 = 16'h1234; req_data1 = 16'hBEEF;
    tick();
    req_valid = 2'b11;
    wait_rsp(lat, low);
    chk("bp_lat", lat, RSP_EDGES);
    ok = 1;
    for (int i = 0; i < 10; i++) begin
      if (!rsp_valid || rsp_data !== 32'hA5A5_1234 || rsp_id !== 1'b0 || req_ready !== 2'b00)
        ok = 0;
      tick();
    end
    chk("bp_stable", ok, 1);
    chk("bp_hold_data", rsp_data, 32'hA5A5_1234);
    rsp_ready = 1'b1;
    tick();
    chk("bp_release_idle", busy, 0);
    chk("bp_release_grant", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    chk("bp_next_busy", busy, 1);
    wait_rsp(lat, low);
    chk("bp_next_id", rsp_id, 1);
    chk("bp_next_data", rsp_data, 32'hA5A5_BEEF);
    tick();

    // Reset in the middle of RUN.
    req_valid = 2'b01; req_data0 = 16'h5555;
    tick();
    req_valid = 2'b00;
    for (int i = 0; i < 10; i++) tick();
    chk("abort_in_run", conv_rst, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_conv_rst", conv_rst, 1);
    chk("abort_busy", busy, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_conv_in", conv_in, 0);
    tick();
    rst_n = 1'b1;
    ok = 1;
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid) ok = 0;
      tick();
    end
    chk("abort_no_rsp", ok, 1);
    req_valid = 2'b11; req_data0 = 16'h0042;
    #1 chk("abort_reset_grant", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    wait_rsp(lat, low);
    chk("abort_after_lat", lat, RSP_EDGES);
    chk("abort_after_data", rsp_data, 32'hA5A5_0042);
    tick();

    // Back-to-back on port 0 with rsp_ready held high.
    req_valid = 2'b01;
    t_prev = 0;
    for (int i = 0; i < 3; i++) begin
      req_data0 = vals[i];
      #1 chk("b2b_ready", req_ready, 2'b01);
      tick();
      t_now = cyc;
      if (i > 0) chk("b2b_spacing", t_now - t_prev, RSP_EDGES + 2);
      t_prev = t_now;
      wait_rsp(lat, low);
      chk("b2b_data", rsp_data, {16'hA5A5, vals[i]});
      tick();
    end
    req_valid = 2'b00;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
